bf_prog_mem: RTL and testbench
==============================

Name: bf_prog_mem

Overview:
- Loadable Brainfuck program memory. Successor to the fixed-program opcode ROM.
- Accepts an ASCII byte stream, keeps only the 8 BF characters and stores them as 3-bit opcodes.
- Program length is a runtime register instead of a constant.
- Sits between the UART receive path (loader side) and the CPU fetch stage (read side); read port has registered 1-cycle latency.

Parameters:
DEPTH, 1024, number of opcode entries; power of two, at least 16.
AW, $clog2(DEPTH), address width; derived, not overridden.
FILL_CODE, 3'b111, opcode returned for out-of-range or blocked reads.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: enter or restart LOAD
load_valid  in  1  load_data valid
load_data  in  8  ASCII program byte
load_ready  out  1  byte accepted when load_valid && load_ready
load_end  in  1  pulse: commit program, return to RUN
rd_en  in  1  fetch request
rd_addr  in  AW  fetch address
rd_code  out  3  opcode, valid 1 cycle after rd_en
rd_overrun  out  1  registered with rd_code; address beyond program or read blocked
prog_len  out  AW+1  committed program length
loading  out  1  high in LOAD
load_full  out  1  high in LOAD when write pointer == DEPTH
bracket_err  out  1  sticky bracket-mismatch flag (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values: state RUN, wptr 0, prog_len 0, rd_code FILL_CODE, rd_overrun 1, loading 0, load_ready 0, load_full 0, bracket_err 0. Memory contents are undefined after reset.
- Opcode encoding:
  - '+' 111, '-' 110, '>' 101, '<' 100
  - '[' 011, ']' 010, '.' 001, ',' 000
  - Any other byte is consumed (load_ready honoured) but not written, and wptr does not advance.
- FSM has 2 states, RUN and LOAD:
  - RUN -> LOAD on load_start: wptr <= 0. prog_len holds its old value until commit.
  - LOAD -> LOAD on load_start: wptr <= 0. The byte presented in that cycle is dropped.
  - LOAD -> RUN on load_end: prog_len <= final wptr. If load_valid && load_ready in the same cycle, that byte is written and counted first.
  - load_end in RUN is ignored.
- load_ready = (state == LOAD) && (wptr < DEPTH). At wptr == DEPTH, load_full = 1 and the stream stalls; load_end still commits prog_len = DEPTH.
- Memory write is synchronous: mem[wptr] <= opcode, wptr <= wptr + 1.
- Reads:
  - On rd_en, rd_code and rd_overrun update on the next clk edge. Without rd_en, both hold.
  - RUN with rd_addr < prog_len: rd_code = mem[rd_addr], rd_overrun = 0.
  - RUN with rd_addr >= prog_len: rd_code = FILL_CODE, rd_overrun = 1. The compare is unsigned at AW+1 bits.
  - LOAD (including the load_start cycle): rd_code = FILL_CODE, rd_overrun = 1.
- Empty commit (load_start then load_end, no valid bytes): prog_len = 0, so every read overruns.
- Reset mid-load: returns to RUN with prog_len 0. The partial program is discarded.

Optional Feature:
- Macro BF_BRACKET_CHECK_EN.
- Defined:
  - A signed depth counter (AW+1 bits) clears on load_start.
  - Each stored '[' adds 1 and each stored ']' subtracts 1.
  - A ']' at depth 0 sets bracket_err.
  - Commit with depth != 0 sets bracket_err.
  - bracket_err is sticky until load_start or reset.
  - The program is still committed; the CPU decides whether to run it.
- Undefined: bracket_err tied to 0 and no counter is synthesised.

Test Plan:
- Reset, then rd_en at addr 0 -> rd_code 3'b111, rd_overrun 1, prog_len 0.
- Load "+[-]>." then load_end, then read addrs 0..5 -> codes 111, 011, 110, 010, 101, 001; rd_overrun 0 each, 1 cycle latency; addr 6 -> 111 with overrun 1; prog_len 6.
- Load "a+\n-x" -> prog_len 2; addr 0 = 111, addr 1 = 110; the non-BF bytes each take a load_ready handshake.
- DEPTH = 16: stream 20 '>' bytes -> load_ready drops after 16, load_full 1; load_end gives prog_len 16; addr 15 = 101 with overrun 0.
- load_start mid-load after 5 bytes, then load "," and end -> prog_len 1, addr 0 = 000. Reads during LOAD return overrun 1. load_end with a simultaneous valid '.' stores it (prog_len 2).
- BF_BRACKET_CHECK_EN: "]" -> bracket_err 1 immediately. "[[]" -> bracket_err 1 at commit. "[]" -> bracket_err 0. A following load_start clears the flag.

Source files
------------

// File: rtl/bf_prog_mem.sv
// Loadable Brainfuck program memory: filters an ASCII stream into 3-bit opcodes and serves registered fetches.
// Optional bracket-balance checking is enabled by defining BF_BRACKET_CHECK_EN.
module bf_prog_mem #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [2:0]  FILL_CODE = 3'b111
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load_start,
  input  logic          i_load_valid,
  input  logic [7:0]    i_load_data,
  output logic          o_load_ready,
  input  logic          i_load_end,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [2:0]    o_rd_code,
  output logic          o_rd_overrun,
  output logic [AW:0]   o_prog_len,
  output logic          o_loading,
  output logic          o_load_full,
  output logic          o_bracket_err
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_MAX = (AW+1)'(DEPTH);

  state_t      r_state, w_state_next;
  logic [AW:0] r_wptr;
  logic [AW:0] r_prog_len;
  logic [2:0]  r_rd_code;
  logic        r_rd_overrun;
  logic [2:0]  r_mem [DEPTH];

  logic        w_ready;
  logic        w_is_bf;
  logic [2:0]  w_op;
  logic        w_write;
  logic        w_commit;
  logic        w_rd_block;
  logic        w_in_range;

  // Decode the ASCII byte; anything outside the eight BF characters is consumed but never stored.
  always_comb begin
    w_is_bf = 1'b1;
    w_op    = 3'b000;
    case (i_load_data)
      8'h2B:   w_op = 3'b111;
      8'h2D:   w_op = 3'b110;
      8'h3E:   w_op = 3'b101;
      8'h3C:   w_op = 3'b100;
      8'h5B:   w_op = 3'b011;
      8'h5D:   w_op = 3'b010;
      8'h2E:   w_op = 3'b001;
      8'h2C:   w_op = 3'b000;
      default: w_is_bf = 1'b0;
    endcase
  end

  assign w_ready    = (r_state == LOAD) && (r_wptr < PTR_MAX);
  assign w_write    = (r_state == LOAD) && !i_load_start && i_load_valid && w_ready && w_is_bf;
  assign w_commit   = (r_state == LOAD) && !i_load_start && i_load_end;
  assign w_rd_block = (r_state == LOAD) || i_load_start;
  assign w_in_range = ({1'b0, i_rd_addr} < r_prog_len);

  // A restart wins over a commit presented in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (i_load_start) w_state_next = LOAD;
      LOAD:    if (i_load_start) w_state_next = LOAD;
               else if (i_load_end) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_wptr     <= '0;
      r_prog_len <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_load_start)
        r_wptr <= '0;
      else if (w_write)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_commit)
        r_prog_len <= r_wptr + {{AW{1'b0}}, w_write};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_write)
      r_mem[r_wptr[AW-1:0]] <= w_op;
  end

  // Fetch results hold between requests so the CPU can sample them late.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_code    <= FILL_CODE;
      r_rd_overrun <= 1'b1;
    end else if (i_rd_en) begin
      if (!w_rd_block && w_in_range) begin
        r_rd_code    <= r_mem[i_rd_addr];
        r_rd_overrun <= 1'b0;
      end else begin
        r_rd_code    <= FILL_CODE;
        r_rd_overrun <= 1'b1;
      end
    end
  end

`ifdef BF_BRACKET_CHECK_EN
  logic signed [AW:0] r_depth, w_depth_next;
  logic               r_bracket_err;
  logic               w_err_set;

  // The depth seen at commit includes a byte written in the same cycle.
  always_comb begin
    w_depth_next = r_depth;
    w_err_set    = 1'b0;
    if (w_write && (w_op == 3'b011)) begin
      w_depth_next = r_depth + $signed(PTR_ONE);
    end else if (w_write && (w_op == 3'b010)) begin
      w_depth_next = r_depth - $signed(PTR_ONE);
      if (r_depth == '0)
        w_err_set = 1'b1;
    end
    if (w_commit && (w_depth_next != '0))
      w_err_set = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth       <= '0;
      r_bracket_err <= 1'b0;
    end else if (i_load_start) begin
      r_depth       <= '0;
      r_bracket_err <= 1'b0;
    end else begin
      r_depth <= w_depth_next;
      if (w_err_set)
        r_bracket_err <= 1'b1;
    end
  end

  assign o_bracket_err = r_bracket_err;
`else
  assign o_bracket_err = 1'b0;
`endif

  assign o_load_ready = w_ready;
  assign o_loading    = (r_state == LOAD);
  assign o_load_full  = (r_state == LOAD) && (r_wptr == PTR_MAX);
  assign o_rd_code    = r_rd_code;
  assign o_rd_overrun = r_rd_overrun;
  assign o_prog_len   = r_prog_len;

endmodule

// File: tb/tb_bf_prog_mem.sv
// Directed bench for bf_prog_mem at DEPTH 16; bracket expectations follow BF_BRACKET_CHECK_EN.
module tb_bf_prog_mem;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef BF_BRACKET_CHECK_EN
  localparam logic BRK = 1'b1;
`else
  localparam logic BRK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic          loadStart, loadValid, loadEnd, rdEn;
  logic [7:0]    loadData;
  logic [AW-1:0] rdAddr;
  logic          loadReady, rdOverrun, loading, loadFull, bracketErr;
  logic [2:0]    rdCode;
  logic [AW:0]   progLen;
  int            compared   = 0;
  int            mismatched = 0;
  int            accepted;

  bf_prog_mem #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_load_start(loadStart), .i_load_valid(loadValid), .i_load_data(loadData),
    .o_load_ready(loadReady), .i_load_end(loadEnd),
    .i_rd_en(rdEn), .i_rd_addr(rdAddr),
    .o_rd_code(rdCode), .o_rd_overrun(rdOverrun), .o_prog_len(progLen),
    .o_loading(loading), .o_load_full(loadFull), .o_bracket_err(bracketErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock with the currently driven inputs; outputs settle 1 time unit after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input string tag);
    loadValid = 1'b1;
    loadData  = b;
    checkOutput({tag, "_ready"}, 32'(loadReady), 32'd1);
    applyStimulus();
    loadValid = 1'b0;
  endtask

  task automatic pulseStart();
    loadStart = 1'b1;
    applyStimulus();
    loadStart = 1'b0;
  endtask

  task automatic pulseEnd();
    loadEnd = 1'b1;
    applyStimulus();
    loadEnd = 1'b0;
  endtask

  task automatic loadString(input string s);
    pulseStart();
    for (int i = 0; i < s.len(); i++)
      sendByte(s[i], $sformatf("str_%0d", i));
    pulseEnd();
  endtask

  task automatic readCheck(input int addr, input logic [2:0] code, input logic ov, input string tag);
    rdEn   = 1'b1;
    rdAddr = AW'(addr);
    applyStimulus();
    rdEn   = 1'b0;
    checkOutput({tag, "_code"}, 32'(rdCode), 32'(code));
    checkOutput({tag, "_ovr"}, 32'(rdOverrun), 32'(ov));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0] progCodes [6];
    progCodes = '{3'b111, 3'b011, 3'b110, 3'b010, 3'b101, 3'b001};
    rstN = 1'b0; loadStart = 1'b0; loadValid = 1'b0; loadEnd = 1'b0;
    rdEn = 1'b0; loadData = 8'h00; rdAddr = '0;
    #12;
    checkOutput("rst_code", 32'(rdCode), 32'd7);
    checkOutput("rst_ovr", 32'(rdOverrun), 32'd1);
    checkOutput("rst_len", 32'(progLen), 32'd0);
    checkOutput("rst_loading", 32'(loading), 32'd0);
    checkOutput("rst_ready", 32'(loadReady), 32'd0);
    checkOutput("rst_full", 32'(loadFull), 32'd0);
    checkOutput("rst_berr", 32'(bracketErr), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    readCheck(0, 3'b111, 1'b1, "rst_read");

    loadString("+[-]>.");
    checkOutput("p1_len", 32'(progLen), 32'd6);
    checkOutput("p1_berr", 32'(bracketErr), 32'd0);
    for (int a = 0; a < 6; a++)
      readCheck(a, progCodes[a], 1'b0, $sformatf("p1_a%0d", a));
    readCheck(6, 3'b111, 1'b1, "p1_a6");
    readCheck(1, 3'b011, 1'b0, "p1_a1_again");
    rdAddr = 4'd6;
    applyStimulus();
    checkOutput("hold_code", 32'(rdCode), 32'd3);
    checkOutput("hold_ovr", 32'(rdOverrun), 32'd0);

    loadString("a+\n-x");
    checkOutput("filt_len", 32'(progLen), 32'd2);
    readCheck(0, 3'b111, 1'b0, "filt_a0");
    readCheck(1, 3'b110, 1'b0, "filt_a1");
    readCheck(2, 3'b111, 1'b1, "filt_a2");

    pulseStart();
    checkOutput("full_loading", 32'(loading), 32'd1);
    loadValid = 1'b1;
    loadData  = 8'h3E;
    accepted  = 0;
    for (int i = 0; i < 20; i++) begin
      if (loadReady) accepted++;
      applyStimulus();
    end
    loadValid = 1'b0;
    checkOutput("full_accepted", 32'(accepted), 32'd16);
    checkOutput("full_flag", 32'(loadFull), 32'd1);
    checkOutput("full_ready", 32'(loadReady), 32'd0);
    readCheck(0, 3'b111, 1'b1, "load_read_blocked");
    pulseEnd();
    checkOutput("full_len", 32'(progLen), 32'd16);
    checkOutput("full_flag_run", 32'(loadFull), 32'd0);
    checkOutput("full_loading_run", 32'(loading), 32'd0);
    readCheck(15, 3'b101, 1'b0, "full_a15");
    readCheck(0, 3'b101, 1'b0, "full_a0");

    pulseEnd();
    checkOutput("end_in_run_len", 32'(progLen), 32'd16);

    rdEn = 1'b1; rdAddr = 4'd0; loadStart = 1'b1;
    applyStimulus();
    rdEn = 1'b0; loadStart = 1'b0;
    checkOutput("start_read_code", 32'(rdCode), 32'd7);
    checkOutput("start_read_ovr", 32'(rdOverrun), 32'd1);
    for (int i = 0; i < 5; i++)
      sendByte(8'h2B, $sformatf("pre_%0d", i));
    loadStart = 1'b1; loadValid = 1'b1; loadData = 8'h2B;
    applyStimulus();
    loadStart = 1'b0; loadValid = 1'b0;
    sendByte(8'h2C, "comma");
    pulseEnd();
    checkOutput("restart_len", 32'(progLen), 32'd1);
    readCheck(0, 3'b000, 1'b0, "restart_a0");
    readCheck(1, 3'b111, 1'b1, "restart_a1");

    pulseStart();
    sendByte(8'h2C, "comma2");
    loadEnd = 1'b1; loadValid = 1'b1; loadData = 8'h2E;
    applyStimulus();
    loadEnd = 1'b0; loadValid = 1'b0;
    checkOutput("endbyte_len", 32'(progLen), 32'd2);
    readCheck(1, 3'b001, 1'b0, "endbyte_a1");
    readCheck(0, 3'b000, 1'b0, "endbyte_a0");

    pulseStart();
    pulseEnd();
    checkOutput("empty_len", 32'(progLen), 32'd0);
    readCheck(0, 3'b111, 1'b1, "empty_a0");

    pulseStart();
    sendByte(8'h5D, "close");
    checkOutput("brk_close_now", 32'(bracketErr), 32'(BRK));
    pulseEnd();
    checkOutput("brk_close_end", 32'(bracketErr), 32'(BRK));
    pulseStart();
    checkOutput("brk_clear", 32'(bracketErr), 32'd0);
    sendByte(8'h5B, "o1");
    sendByte(8'h5B, "o2");
    sendByte(8'h5D, "c1");
    checkOutput("brk_open_pre", 32'(bracketErr), 32'd0);
    pulseEnd();
    checkOutput("brk_open_end", 32'(bracketErr), 32'(BRK));
    pulseStart();
    checkOutput("brk_clear2", 32'(bracketErr), 32'd0);
    sendByte(8'h5B, "o3");
    sendByte(8'h5D, "c2");
    pulseEnd();
    checkOutput("brk_bal", 32'(bracketErr), 32'd0);
    checkOutput("brk_bal_len", 32'(progLen), 32'd2);
    readCheck(0, 3'b011, 1'b0, "brk_a0");
    readCheck(1, 3'b010, 1'b0, "brk_a1");

    pulseStart();
    sendByte(8'h2B, "midrst");
    rstN = 1'b0;
    #1;
    checkOutput("midrst_len", 32'(progLen), 32'd0);
    checkOutput("midrst_loading", 32'(loading), 32'd0);
    checkOutput("midrst_ovr", 32'(rdOverrun), 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    readCheck(0, 3'b111, 1'b1, "midrst_a0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
